// File: rtl/pixel_period_meter.sv
// Measures clock-cycle periods between rising edges of the thresholded pixel stream and
// accumulates them per frequency class. Optional PIXEL_PERIOD_METER_LAST_PERIOD_EN adds last_period/period_valid.
module pixel_period_meter #(
  parameter int CLOCK_FREQUENCY   = 100000000,
  parameter int FREQUENCY0        = 7500,
  parameter int FREQUENCY1        = 10000,
  parameter int DEVIATION_PERCENT = 30,
  parameter int COUNTER_WIDTH     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     sample_data,
  output logic [COUNTER_WIDTH-1:0] f0_value,
  output logic [COUNTER_WIDTH-1:0] f1_value,
  output logic [COUNTER_WIDTH-1:0] unknown,
  output logic                     busy
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
  ,
  output logic [COUNTER_WIDTH-1:0] last_period,
  output logic                     period_valid
`endif
);

  localparam int P0 = CLOCK_FREQUENCY / FREQUENCY0;
  localparam int T0 = P0 * DEVIATION_PERCENT / 100;
  localparam int P1 = CLOCK_FREQUENCY / FREQUENCY1;
  localparam int T1 = P1 * DEVIATION_PERCENT / 100;

  localparam logic [COUNTER_WIDTH-1:0] LO0 = COUNTER_WIDTH'(P0 - T0);
  localparam logic [COUNTER_WIDTH-1:0] HI0 = COUNTER_WIDTH'(P0 + T0);
  localparam logic [COUNTER_WIDTH-1:0] LO1 = COUNTER_WIDTH'(P1 - T1);
  localparam logic [COUNTER_WIDTH-1:0] HI1 = COUNTER_WIDTH'(P1 + T1);
  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  state_t                   state;
  logic                     s1, s2, s3;
  logic                     rise;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     saturated;
  logic                     in_w0;
  logic                     in_w1;

  // Saturating add so accumulators stick at all-ones instead of wrapping.
  function automatic logic [COUNTER_WIDTH-1:0] sat_add(input logic [COUNTER_WIDTH-1:0] a,
                                                       input logic [COUNTER_WIDTH-1:0] b);
    logic [COUNTER_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COUNTER_WIDTH] ? '1 : sum[COUNTER_WIDTH-1:0];
  endfunction

  assign rise      = s2 & ~s3;
  assign saturated = &cnt;
  assign in_w0     = !saturated && (cnt >= LO0) && (cnt <= HI0);
  assign in_w1     = !saturated && (cnt >= LO1) && (cnt <= HI1);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sample_data;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      f0_value <= '0;
      f1_value <= '0;
      unknown  <= '0;
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
      last_period  <= '0;
      period_valid <= 1'b0;
`endif
    end else begin
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
      period_valid <= 1'b0;
`endif
      // clear outranks enable and swallows any rise arriving in the same cycle
      if (clear) begin
        f0_value <= '0;
        f1_value <= '0;
        unknown  <= '0;
        cnt      <= '0;
        state    <= enable ? ARMED : IDLE;
        busy     <= enable;
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
        last_period <= '0;
`endif
      end else if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARMED;
            busy  <= 1'b1;
          end
          ARMED: begin
            if (rise) begin
              cnt   <= ONE;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              if (in_w0)      f0_value <= sat_add(f0_value, cnt);
              else if (in_w1) f1_value <= sat_add(f1_value, cnt);
              else            unknown  <= sat_add(unknown, cnt);
              cnt <= ONE;
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
              last_period  <= cnt;
              period_valid <= 1'b1;
`endif
            end else if (!saturated) begin
              cnt <= cnt + ONE;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_period_meter.sv
// Directed bench for pixel_period_meter with a time-stamped scoreboard of expected accumulator values.
// Bench windows follow the integer formula: class 0 = [9,11], class 1 = [18,22] (T1 = 20*10/100 = 2).
module tb_pixel_period_meter;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        sample_data;
  logic [31:0] f0_value;
  logic [31:0] f1_value;
  logic [31:0] unknown;
  logic        busy;
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
  logic [31:0] last_period;
  logic        period_valid;
  int          pv_count = 0;
`endif

  typedef struct {
    time         due;
    int          step;
    logic [31:0] f0;
    logic [31:0] f1;
    logic [31:0] unk;
    logic        busy;
  } expect_t;

  expect_t     sb[$];
  int          n_asserts = 0;
  int          n_fails   = 0;
  logic [31:0] m_f0, m_f1, m_unk;
  logic        m_busy;
  bit          m_measuring;

  pixel_period_meter #(
    .CLOCK_FREQUENCY  (1000),
    .FREQUENCY0       (100),
    .FREQUENCY1       (50),
    .DEVIATION_PERCENT(10),
    .COUNTER_WIDTH    (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .sample_data (sample_data),
    .f0_value    (f0_value),
    .f1_value    (f1_value),
    .unknown     (unknown),
    .busy        (busy)
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
    ,
    .last_period (last_period),
    .period_valid(period_valid)
`endif
  );

  always #5 clock = ~clock;

`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
  always @(negedge clock) if (period_valid === 1'b1) pv_count++;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_expect(input int step, input time delay);
    expect_t e;
    e.due  = $time + delay;
    e.step = step;
    e.f0   = m_f0;
    e.f1   = m_f1;
    e.unk  = m_unk;
    e.busy = m_busy;
    sb.push_back(e);
  endtask

  // Reference classification with the bench's own window constants
  task automatic model_rise(input int gap);
    if (!m_measuring) m_measuring = 1'b1;
    else if (gap >= 9 && gap <= 11) m_f0 += 32'(gap);
    else if (gap >= 18 && gap <= 22) m_f1 += 32'(gap);
    else m_unk += 32'(gap);
  endtask

  task automatic model_zero();
    m_f0 = '0; m_f1 = '0; m_unk = '0; m_measuring = 1'b0;
  endtask

  // Pops expectations once their due time is reached, i.e. after the 3-clock update latency
  initial begin
    expect_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].due <= $time) begin
        e = sb.pop_front();
        check($sformatf("f0_step%0d", e.step), f0_value, e.f0);
        check($sformatf("f1_step%0d", e.step), f1_value, e.f1);
        check($sformatf("unknown_step%0d", e.step), unknown, e.unk);
        check($sformatf("busy_step%0d", e.step), {31'b0, busy}, {31'b0, e.busy});
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clock);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic first_rise(input int step);
    @(negedge clock) sample_data = 1'b0;
    @(negedge clock) sample_data = 1'b1;
    model_rise(0);
    push_expect(step, 30);
  endtask

  task automatic next_rise(input int gap, input int step);
    @(negedge clock) sample_data = 1'b0;
    repeat (gap - 2) @(negedge clock);
    @(negedge clock) sample_data = 1'b1;
    model_rise(gap);
    push_expect(step, 30);
  endtask

  task automatic apply_clear(input int step);
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    model_zero();
    push_expect(step, 0);
    drain();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; sample_data = 1'b0;
    model_zero();
    m_busy = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    push_expect(0, 0);
    drain();

    $display("[TB] period 10 train");
    @(negedge clock) enable = 1'b1;
    m_busy = 1'b1;
    first_rise(1);
    repeat (4) next_rise(10, 1);
    drain();

    $display("[TB] period 20 then 15");
    apply_clear(2);
    first_rise(2);
    repeat (3) next_rise(20, 2);
    repeat (2) next_rise(15, 2);
    drain();

    $display("[TB] boundary periods");
    apply_clear(3);
    first_rise(3);
    next_rise(9, 3);
    next_rise(11, 3);
    next_rise(12, 3);
    next_rise(8, 3);
    drain();

    $display("[TB] enable gap");
    @(negedge clock) enable = 1'b0;
    m_busy = 1'b0;
    m_measuring = 1'b0;
    repeat (50) @(negedge clock);
    push_expect(4, 0);
    drain();
    @(negedge clock) enable = 1'b1;
    m_busy = 1'b1;
    first_rise(4);
    next_rise(10, 4);
    drain();

    $display("[TB] clear coincident with rise");
    @(negedge clock) sample_data = 1'b0;
    repeat (9) @(negedge clock);
    sample_data = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    model_zero();
    push_expect(5, 0);
    drain();
    next_rise(10, 5);
    next_rise(10, 5);
    drain();

    $display("[TB] period 20 and reset mid-measure");
    apply_clear(6);
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
    pv_count = 0;
`endif
    first_rise(6);
    repeat (3) next_rise(20, 6);
    drain();
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
    check("period_valid_pulses", 32'(pv_count), 32'd3);
    check("last_period", last_period, 32'd20);
`endif
    @(negedge clock) sample_data = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    model_zero();
    m_busy = 1'b0;
    push_expect(7, 10);
    drain();
`ifdef PIXEL_PERIOD_METER_LAST_PERIOD_EN
    check("last_period_reset", last_period, 32'd0);
    check("period_valid_reset", {31'b0, period_valid}, 32'd0);
`endif
    @(negedge clock) reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
